// File: rtl/i2c_txn_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_txn_arbiter
//
// Round-robin arbiter and sequencer in front of the single I2C master core.
// Up to N_REQ requesters post register read/write requests. One request is
// granted at a time. Its command fields are loaded into the core, the core
// is started, and the result is returned to the granted requester.
// This block is the only driver of the core's command inputs.
//
// Optional feature macro: I2C_ARB_TIMEOUT_EN
//   When defined, a watchdog aborts a transaction that stays in WAIT for
//   TIMEOUT_CYC cycles. The requester then gets an error response.
//   When undefined, WAIT lasts until i2c_done and i2c_abort is tied low.
//
// Parameters
//   N_REQ        number of requesters (2..8)
//   TIMEOUT_CYC  watchdog limit in clk100mhz cycles (timeout build only)
//
// Ports
//   clk100mhz      system clock, rising edge
//   res            asynchronous active-low reset
//   req_valid      per-requester request, held until req_ack
//   req_rw         per-requester direction, 1 = read
//   req_slave      7-bit slave address per requester, packed
//   req_reg        8-bit register address per requester, packed
//   req_wdata      8-bit write data per requester, packed
//   req_ack        one-hot pulse: request captured
//   rsp_valid      one-hot pulse: transaction finished
//   rsp_rdata      read data, valid with rsp_valid
//   rsp_err        NACK or timeout, valid with rsp_valid
//   addr_to_send   {slave, rw} to core
//   addr_reg_send  register address to core
//   data_to_send   write data to core
//   rw             direction to core
//   i2c_start      1-cycle start pulse to core
//   i2c_abort      1-cycle abort pulse to core
//   i2c_done       core completion pulse
//   i2c_nack       core NACK flag, sampled with i2c_done
//   addr_reg_read  core read data, sampled with i2c_done
// ---------------------------------------------------------------------------
module i2c_txn_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                 clk100mhz,
  input  logic                 res,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ-1:0]     req_rw,
  input  logic [7*N_REQ-1:0]   req_slave,
  input  logic [8*N_REQ-1:0]   req_reg,
  input  logic [8*N_REQ-1:0]   req_wdata,
  output logic [N_REQ-1:0]     req_ack,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_err,
  output logic [7:0]           addr_to_send,
  output logic [7:0]           addr_reg_send,
  output logic [7:0]           data_to_send,
  output logic                 rw,
  output logic                 i2c_start,
  output logic                 i2c_abort,
  input  logic                 i2c_done,
  input  logic                 i2c_nack,
  input  logic [7:0]           addr_reg_read
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] grant;    // requester currently being served
  logic [PW-1:0] ptr;      // round-robin search start
  logic [PW-1:0] winner;   // round-robin pick for this cycle
  logic          any_req;
  logic          expired;  // watchdog fired this cycle (never when i2c_done)

  // -------------------------------------------------------------------------
  // Round-robin pick: the first valid requester at or after ptr, wrapping.
  // The loop runs from the farthest offset down to offset 0, so the closest
  // valid requester is the last assignment made and therefore wins.
  // -------------------------------------------------------------------------
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(ptr) + k) % N_REQ]) begin
        winner  = PW'((int'(ptr) + k) % N_REQ);
        any_req = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Watchdog
  // -------------------------------------------------------------------------
`ifdef I2C_ARB_TIMEOUT_EN
  logic [16:0] wd_cnt;

  // Held at zero outside WAIT, so it always starts from zero when WAIT is
  // entered. During the k-th WAIT cycle it holds k-1, so expiry lands on the
  // TIMEOUT_CYC-th WAIT cycle. A coincident i2c_done takes precedence.
  always_ff @(posedge clk100mhz or negedge res) begin
    if (!res) begin
      wd_cnt <= '0;
    end else if (state != WAIT) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 17'd1;
    end
  end

  assign expired = (state == WAIT) && (wd_cnt == 17'(TIMEOUT_CYC - 1)) && !i2c_done;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign expired        = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk100mhz or negedge res) begin
    if (!res) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic. i2c_done only matters in WAIT.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (any_req) state_next = GRANT;
      GRANT:   state_next = START;
      START:   state_next = WAIT;
      WAIT:    if (i2c_done || expired) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: pulse outputs (decoded from state)
  // -------------------------------------------------------------------------
  always_comb begin
    req_ack   = '0;
    rsp_valid = '0;
    i2c_start = 1'b0;
    i2c_abort = 1'b0;
    unique case (state)
      GRANT:   req_ack[grant]   = 1'b1;
      START:   i2c_start        = 1'b1;
      WAIT:    i2c_abort        = expired;
      RESP:    rsp_valid[grant] = 1'b1;
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: grant/pointer bookkeeping, command fields and response capture.
  // The command fields are loaded on the IDLE->GRANT edge, so they are already
  // stable during the GRANT cycle. They are held through RESP and cleared on
  // the way back to IDLE.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk100mhz or negedge res) begin
    if (!res) begin
      grant         <= '0;
      ptr           <= '0;
      addr_to_send  <= 8'h00;
      addr_reg_send <= 8'h00;
      data_to_send  <= 8'h00;
      rw            <= 1'b0;
      rsp_rdata     <= 8'h00;
      rsp_err       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant         <= winner;
            addr_to_send  <= {req_slave[7*winner +: 7], req_rw[winner]};
            addr_reg_send <= req_reg[8*winner +: 8];
            data_to_send  <= req_wdata[8*winner +: 8];
            rw            <= req_rw[winner];
            rsp_rdata     <= 8'h00;
            rsp_err       <= 1'b0;
          end
        end
        WAIT: begin
          if (i2c_done) begin
            // Writes report 0x00 whatever the core leaves on its read bus.
            rsp_rdata <= rw ? addr_reg_read : 8'h00;
            rsp_err   <= i2c_nack;
          end else if (expired) begin
            rsp_rdata <= 8'h00;
            rsp_err   <= 1'b1;
          end
        end
        RESP: begin
          ptr           <= (grant == PW'(N_REQ - 1)) ? '0 : PW'(int'(grant) + 1);
          addr_to_send  <= 8'h00;
          addr_reg_send <= 8'h00;
          data_to_send  <= 8'h00;
          rw            <= 1'b0;
          rsp_rdata     <= 8'h00;
          rsp_err       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/i2c_txn_arbiter.md
# i2c_txn_arbiter

Round-robin transaction arbiter and sequencer sitting in front of the single I2C master core. It accepts register read/write requests from up to N_REQ on-chip requesters, grants one at a time, and loads the core's command fields. The fields are slave address plus R/W bit, register address and write data. It then pulses start, waits for completion and returns read data or error status to the granted requester. It is the only block allowed to drive the core's command inputs.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- TIMEOUT_CYC, 100000, watchdog limit in clk100mhz cycles (1 ms), used only with I2C_ARB_TIMEOUT_EN

Ports:
- clk100mhz  in  1  system clock, all logic on rising edge
- res  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  per-requester request, held until matching req_ack
- req_rw  in  N_REQ  per-requester direction, 1 = read, 0 = write
- req_slave  in  7*N_REQ  slave address, requester i at [7i+6:7i]
- req_reg  in  8*N_REQ  register address, requester i at [8i+7:8i]
- req_wdata  in  8*N_REQ  write data, ignored for reads
- req_ack  out  N_REQ  one-hot, 1-cycle pulse: request captured
- rsp_valid  out  N_REQ  one-hot, 1-cycle pulse: transaction finished
- rsp_rdata  out  8  read data, valid with rsp_valid
- rsp_err  out  1  NACK or timeout, valid with rsp_valid
- addr_to_send  out  8  {slave[6:0], rw} to core
- addr_reg_send  out  8  register address to core
- data_to_send  out  8  write data to core
- rw  out  1  direction to core
- i2c_start  out  1  1-cycle start pulse to core
- i2c_abort  out  1  1-cycle abort pulse to core
- i2c_done  in  1  core completion pulse
- i2c_nack  in  1  core NACK flag, sampled with i2c_done
- addr_reg_read  in  8  core read data, sampled with i2c_done

## Operation
- FSM states: IDLE, GRANT, START, WAIT, RESP.
- IDLE: when any req_valid is set, select winner g by round-robin starting at pointer ptr, then go to GRANT. Otherwise stay in IDLE.
- GRANT: pulse req_ack[g]. Register req_slave/req_reg/req_wdata/req_rw of g onto core outputs. Go to START.
- START: i2c_start = 1 for exactly this cycle. Go to WAIT.
- WAIT: on i2c_done, capture addr_reg_read into rsp_rdata (reads only; writes leave 0x00) and i2c_nack into rsp_err. Go to RESP.
- RESP: pulse rsp_valid[g]. Set ptr = (g+1) mod N_REQ. Go to IDLE.
- Core command outputs hold stable from GRANT through RESP. They clear to 0 on the return to IDLE.
- rsp_rdata/rsp_err are meaningful only while rsp_valid is set.
- i2c_done is ignored in every state except WAIT.
- Requests arriving while busy wait. No request is dropped. A requester may drop req_valid before req_ack only by withdrawing; withdrawal is not an error.
- Simultaneous requests: the lowest index at or after ptr wins, wrapping past N_REQ-1 to 0.
- Reset mid-operation: state returns to IDLE with no rsp_valid, ptr returns to 0 and all outputs clear. The core is reset by the same res.

## Timing
- Reset values: req_ack = 0, rsp_valid = 0, rsp_rdata = 0x00, rsp_err = 0, addr_to_send = 0x00, addr_reg_send = 0x00, data_to_send = 0x00, rw = 0, i2c_start = 0, i2c_abort = 0.
- req_valid seen in IDLE at cycle T gives req_ack at T+1 and i2c_start at T+2.
- i2c_done seen at cycle D gives rsp_valid at D+1.
- The next grant can occur at the IDLE cycle D+2, so the back-to-back request gap is 3 cycles after rsp_valid to the next i2c_start.
- The core must not assert i2c_done in the same cycle as i2c_start.

## Configuration
- I2C_ARB_TIMEOUT_EN defined:
  - A 17-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYC with no i2c_done, pulse i2c_abort for 1 cycle and go to RESP with rsp_err = 1 and rsp_rdata = 0x00.
  - If i2c_done and the expiry coincide, i2c_done wins.
- I2C_ARB_TIMEOUT_EN undefined: no counter, i2c_abort tied to 0, WAIT lasts indefinitely, TIMEOUT_CYC unused.

## Test plan
- Single write: req 1 has slave 0x50, reg 0x10, wdata 0xA5, rw = 0. Expect addr_to_send = 0xA0, addr_reg_send = 0x10, data_to_send = 0xA5, req_ack[1] at T+1 and i2c_start at T+2. A done after 20 cycles gives rsp_valid[1] with rsp_err = 0.
- Contention: all 4 requesters valid at once from reset. Grants go in order 0, 1, 2, 3. Then re-raise 0 and 2 with ptr at 0: grant 0, then 2.
- Read: req 2 has slave 0x3C, reg 0x05, rw = 1, and the core returns addr_reg_read = 0x7E with done. Expect addr_to_send = 0x79, then rsp_valid[2] with rsp_rdata = 0x7E.
- NACK: i2c_nack = 1 with i2c_done. Expect rsp_err = 1, and the next request is still served.
- Timeout (macro on, TIMEOUT_CYC = 50): no done. Expect i2c_abort at WAIT cycle 50, then rsp_valid with rsp_err = 1. Macro off: no response and i2c_abort stays 0.
- Reset in WAIT: deassert res. All outputs go 0 asynchronously and no rsp_valid occurs. After release, a new request on req 3 is granted first.
